mem_block_image_mp: RTL and testbench

- Parametrised successor to the fixed 4x4-complex image memory block: a ROWS x COLS array of complex lanes, each lane DATA_W real plus DATA_W imaginary, DEPTH words deep.
- Adds per-lane write mask, configurable read latency with a valid strobe, out-of-range address protection, and a hardware clear sweep with busy flag.
- Sits between the FFT/transform datapath and the conv-layer controller as image/kernel buffer storage.

---
 rtl/mem_block_image_mp.sv | 166 ++++++++++++++++
 tb/tb_mem_block_image_mp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_image_mp.sv
// mem_block_image_mp
//   Image/kernel buffer between the FFT/transform datapath and the conv-layer
//   controller. Each word is a ROWS x COLS array of complex lanes. Lane
//   k = i*COLS + j holds its real part at [2*DATA_W*k +: DATA_W] and its
//   imaginary part at [2*DATA_W*k + DATA_W +: DATA_W].
//
// Optional feature macro: MEM_BLOCK_WR_BYPASS_EN
//   defined   : same-cycle wr/re to the same valid address returns write-first
//               data (masked lanes see new wdata, other lanes the old word).
//   undefined : read-first, so the read returns the pre-write contents.
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst    : synchronous active-high reset
//   wr     : write enable; waddr/wmask/wdata qualify it
//   waddr  : write address, writes at or above DEPTH are dropped
//   wmask  : per-lane write enable, bit k = lane k
//   wdata  : write word
//   re     : read enable; raddr qualifies it
//   raddr  : read address, reads at or above DEPTH return zero
//   rdata  : read word, holds its value while rvalid is low
//   rvalid : one-cycle strobe, RD_LAT cycles after each accepted read
//   clr    : single-cycle pulse starting a clear sweep of the whole memory
//   busy   : clear sweep in progress; wr, re and clr are ignored meanwhile
//
// Handshake: a read is accepted in any cycle with re=1 and busy=0; there is
// no back-pressure, and exactly one rvalid pulse follows each accepted read.
// busy is the registered image of the clear FSM state (1 = SWEEP).
module mem_block_image_mp #(
  parameter int DATA_W = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DEPTH  = 8192,
  parameter int RD_LAT = 1,
  localparam int LANES  = ROWS * COLS,
  localparam int LANE_W = 2 * DATA_W,
  localparam int WORD_W = LANES * LANE_W,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [AW-1:0]     waddr,
  input  logic [LANES-1:0]  wmask,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  input  logic              clr,
  output logic              busy
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              waddr_ok, raddr_ok, wr_ok, rd_ok;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] s1_data;
  logic              s1_valid;

  assign waddr_ok = {1'b0, waddr} < DEPTH_C;
  assign raddr_ok = {1'b0, raddr} < DEPTH_C;
  // clr takes priority over a write in the same idle cycle; a read in that
  // cycle is still accepted because the sweep only starts on the next edge.
  assign wr_ok    = wr && (state == IDLE) && !clr && waddr_ok;
  assign rd_ok    = re && (state == IDLE);

  // Clear FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never reset. The sweep keys off the current state, so the
  // word at cnt is still zeroed on an edge where rst aborts the sweep.
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (wmask[k]) mem[waddr][k*LANE_W +: LANE_W] <= wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (raddr_ok) rd_word = mem[raddr];
`ifdef MEM_BLOCK_WR_BYPASS_EN
    if (wr_ok && raddr_ok && (waddr == raddr)) begin
      for (int k = 0; k < LANES; k++) begin
        if (wmask[k]) rd_word[k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
      end
    end
`endif
  end

  // First read stage; data only moves on an accepted read so the output
  // holds its last value between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_data <= rd_word;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign rdata  = s1_data;
      assign rvalid = s1_valid;
    end else if (RD_LAT == 2) begin : g_lat2
      logic [WORD_W-1:0] s2_data;
      logic              s2_valid;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end
      assign rdata  = s2_data;
      assign rvalid = s2_valid;
    end else begin : g_bad_lat
      $error("mem_block_image_mp: RD_LAT must be 1 or 2");
    end
  endgenerate

endmodule

// File: tb/tb_mem_block_image_mp.sv
// Bench for mem_block_image_mp. Two instances: dut_a (DEPTH=16, RD_LAT=1)
// carries the write/mask/collision and clear-sweep sequences, dut_b
// (DEPTH=12, RD_LAT=2) carries the pipelined and out-of-range cases.
module tb_mem_block_image_mp;
  localparam int DW = 16;
  localparam int LN = 16;
  localparam int W  = LN * 2 * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         a_wr, a_re, a_clr, a_rvalid, a_busy;
  logic [3:0]   a_waddr, a_raddr;
  logic [LN-1:0] a_wmask;
  logic [W-1:0] a_wdata, a_rdata;
  logic         b_wr, b_re, b_clr, b_rvalid, b_busy;
  logic [3:0]   b_waddr, b_raddr;
  logic [LN-1:0] b_wmask;
  logic [W-1:0] b_wdata, b_rdata;

  mem_block_image_mp #(.DATA_W(DW), .ROWS(4), .COLS(4), .DEPTH(16), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .wr(a_wr), .waddr(a_waddr), .wmask(a_wmask), .wdata(a_wdata),
    .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid), .clr(a_clr), .busy(a_busy));

  mem_block_image_mp #(.DATA_W(DW), .ROWS(4), .COLS(4), .DEPTH(12), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .wr(b_wr), .waddr(b_waddr), .wmask(b_wmask), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid), .clr(b_clr), .busy(b_busy));

  // scoreboard
  logic [W-1:0] a_exp_q[$];
  int           a_due_q[$];
  logic [W-1:0] b_exp_q[$];
  int           b_due_q[$];
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [15:0] mask;
    logic [15:0] a_re, a_im;
    bit          inc;
    logic [15:0] b_re, b_im;
    logic [15:0] mix;
  } vec_t;
  vec_t tbl[10];

  // lanes in mix take (b_re,b_im); others take (a_re,a_im), plus lane index if inc
  function automatic logic [W-1:0] make_word(logic [15:0] re_v, logic [15:0] im_v, bit inc,
                                             logic [15:0] b_re, logic [15:0] b_im, logic [15:0] mix);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < LN; k++) begin
      w[k*2*DW +: DW]      = mix[k] ? b_re : re_v + (inc ? 16'(k) : 16'd0);
      w[k*2*DW + DW +: DW] = mix[k] ? b_im : im_v + (inc ? 16'(k) : 16'd0);
    end
    return w;
  endfunction

  function automatic logic [W-1:0] fill(logic [15:0] v);
    return make_word(v, v, 1'b0, 16'd0, 16'd0, 16'd0);
  endfunction

  function automatic logic [W-1:0] pat(int base, int addr);
    return make_word(16'(base + addr*16), 16'(base + 16'h0800 + addr*16), 1'b1, 16'd0, 16'd0, 16'd0);
  endfunction

  task automatic chk_w(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and retire any read result there.
  task automatic step();
    logic [W-1:0] e;
    int d;
    @(negedge clk);
    if (!rst && a_rvalid) begin
      if (a_exp_q.size() == 0) chk_i("a_spurious_rvalid", 1, 0);
      else begin
        e = a_exp_q.pop_front(); d = a_due_q.pop_front();
        chk_w("a_rdata", a_rdata, e);
        chk_i("a_latency", cyc, d);
      end
    end
    if (!rst && b_rvalid) begin
      if (b_exp_q.size() == 0) chk_i("b_spurious_rvalid", 1, 0);
      else begin
        e = b_exp_q.pop_front(); d = b_due_q.pop_front();
        chk_w("b_rdata", b_rdata, e);
        chk_i("b_latency", cyc, d);
      end
    end
  endtask

  // driver tasks
  task automatic a_set(input logic wr, input logic [3:0] wa, input logic [15:0] m, input logic [W-1:0] wd,
                       input logic re, input logic [3:0] ra, input logic cl);
    a_wr = wr; a_waddr = wa; a_wmask = m; a_wdata = wd; a_re = re; a_raddr = ra; a_clr = cl;
  endtask

  task automatic a_idle();
    a_set(1'b0, 4'd0, 16'd0, '0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic a_write(input logic [3:0] wa, input logic [15:0] m, input logic [W-1:0] wd);
    step(); a_set(1'b1, wa, m, wd, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic a_read(input logic [3:0] ra, input logic [W-1:0] exp);
    step(); a_set(1'b0, 4'd0, 16'd0, '0, 1'b1, ra, 1'b0);
    a_exp_q.push_back(exp); a_due_q.push_back(cyc + 1);
  endtask

  task automatic b_set(input logic wr, input logic [3:0] wa, input logic [W-1:0] wd,
                       input logic re, input logic [3:0] ra);
    b_wr = wr; b_waddr = wa; b_wmask = 16'hFFFF; b_wdata = wd; b_re = re; b_raddr = ra; b_clr = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] wa, input logic [W-1:0] wd);
    step(); b_set(1'b1, wa, wd, 1'b0, 4'd0);
  endtask

  task automatic b_read(input logic [3:0] ra, input logic [W-1:0] exp);
    step(); b_set(1'b0, 4'd0, '0, 1'b1, ra);
    b_exp_q.push_back(exp); b_due_q.push_back(cyc + 2);
  endtask

  initial begin
    int n_busy;
    logic [W-1:0] coll_exp;

    // reset
    a_idle(); b_set(1'b0, 4'd0, '0, 1'b0, 4'd0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_w("a_rdata_reset", a_rdata, '0);
    chk_i("a_rvalid_reset", int'(a_rvalid), 0);
    chk_i("a_busy_reset", int'(a_busy), 0);
    chk_w("b_rdata_reset", b_rdata, '0);
    chk_i("b_rvalid_reset", int'(b_rvalid), 0);
    chk_i("b_busy_reset", int'(b_busy), 0);

    // write/read/mask vectors on dut_a
    tbl[0] = '{1'b1, 4'd5, 16'hFFFF, 16'd0,    16'd100,  1'b1, 16'h0,    16'h0,    16'h0000};
    tbl[1] = '{1'b0, 4'd5, 16'h0000, 16'd0,    16'd100,  1'b1, 16'h0,    16'h0,    16'h0000};
    tbl[2] = '{1'b1, 4'd7, 16'hFFFF, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0,    16'h0,    16'h0000};
    tbl[3] = '{1'b1, 4'd7, 16'h0001, 16'h5555, 16'h5555, 1'b0, 16'h0,    16'h0,    16'h0000};
    tbl[4] = '{1'b0, 4'd7, 16'h0000, 16'hAAAA, 16'hAAAA, 1'b0, 16'h5555, 16'h5555, 16'h0001};
    tbl[5] = '{1'b1, 4'd3, 16'hFFFF, 16'h1234, 16'h4321, 1'b0, 16'h0,    16'h0,    16'h0000};
    tbl[6] = '{1'b1, 4'd3, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0,    16'h0,    16'h0000};
    tbl[7] = '{1'b0, 4'd3, 16'h0000, 16'h1234, 16'h4321, 1'b0, 16'h0,    16'h0,    16'h0000};
    tbl[8] = '{1'b1, 4'd3, 16'h8001, 16'h00EE, 16'h00EF, 1'b0, 16'h0,    16'h0,    16'h0000};
    tbl[9] = '{1'b0, 4'd3, 16'h0000, 16'h1234, 16'h4321, 1'b0, 16'h00EE, 16'h00EF, 16'h8001};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr)
        a_write(tbl[i].addr, tbl[i].mask, make_word(tbl[i].a_re, tbl[i].a_im, tbl[i].inc, 16'd0, 16'd0, 16'd0));
      else
        a_read(tbl[i].addr, make_word(tbl[i].a_re, tbl[i].a_im, tbl[i].inc, tbl[i].b_re, tbl[i].b_im, tbl[i].mix));
    end

    // same-cycle write/read collision at addr 9
    a_write(4'd9, 16'hFFFF, fill(16'h0001));
`ifdef MEM_BLOCK_WR_BYPASS_EN
    coll_exp = fill(16'h0002);
`else
    coll_exp = fill(16'h0001);
`endif
    step(); a_set(1'b1, 4'd9, 16'hFFFF, fill(16'h0002), 1'b1, 4'd9, 1'b0);
    a_exp_q.push_back(coll_exp); a_due_q.push_back(cyc + 1);
    a_read(4'd9, fill(16'h0002));

    // dut_b: RD_LAT=2 back-to-back and out-of-range
    step(); a_idle();
    b_write(4'd0, pat(16'h4000, 0));
    b_write(4'd1, pat(16'h4000, 1));
    b_write(4'd2, pat(16'h4000, 2));
    b_write(4'd11, pat(16'h4000, 11));
    b_write(4'd13, pat(16'h4000, 13));
    b_read(4'd0, pat(16'h4000, 0));
    b_read(4'd1, pat(16'h4000, 1));
    b_read(4'd2, pat(16'h4000, 2));
    b_read(4'd14, '0);
    b_read(4'd13, '0);
    b_read(4'd11, pat(16'h4000, 11));
    step(); b_set(1'b0, 4'd0, '0, 1'b0, 4'd0);
    repeat (3) step();

    // full clear sweep: busy length, write while busy dropped
    for (int i = 0; i < 16; i++) a_write(4'(i), 16'hFFFF, pat(16'h1000, i));
    step(); a_set(1'b0, 4'd0, 16'd0, '0, 1'b1, 4'd3, 1'b1);
    a_exp_q.push_back(pat(16'h1000, 3)); a_due_q.push_back(cyc + 1);
    n_busy = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (!a_busy) break;
      n_busy++;
      if (t == 10) a_set(1'b1, 4'd2, 16'hFFFF, fill(16'h7777), 1'b1, 4'd2, 1'b0);
      else a_idle();
    end
    a_idle();
    chk_i("a_busy_cycles", n_busy, 16);
    for (int i = 0; i < 16; i++) a_read(4'(i), '0);

    // sweep aborted by reset after 5 busy cycles
    for (int i = 0; i < 16; i++) a_write(4'(i), 16'hFFFF, pat(16'h3000, i));
    step(); a_set(1'b1, 4'd10, 16'hFFFF, fill(16'h7777), 1'b1, 4'd3, 1'b1);
    a_exp_q.push_back(pat(16'h3000, 3)); a_due_q.push_back(cyc + 1);
    n_busy = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      a_idle();
      if (a_busy) n_busy++;
      if (n_busy == 5) break;
    end
    chk_i("a_busy_before_rst", n_busy, 5);
    rst = 1'b1;
    step();
    chk_i("a_busy_after_rst", int'(a_busy), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) a_read(4'(i), (i < 5) ? '0 : pat(16'h3000, i));

    // drain
    for (int i = 0; i < 5; i++) begin step(); a_idle(); end
    chk_i("a_queue_drained", a_exp_q.size(), 0);
    chk_i("b_queue_drained", b_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
